// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register; define FETCH_ALIGN_CHECK_EN for the sticky misaligned-branch flag
module fetch_stage #(
    parameter int                  ADDR_W    = 22,
    parameter int                  INSTR_W   = 22,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instr_d,
    output logic [ADDR_W-1:0]  pc_d,
    output logic [ADDR_W-1:0]  pc_plus4_d,
    output logic               valid_d,
    output logic               misalign_err
);
    logic [ADDR_W-1:0] pc_q, pc_inc, pc_next, target;
    assign pc_inc    = pc_q + ADDR_W'(4);
    assign target    = {branch_target[ADDR_W-1:2], 2'b00};
    assign imem_addr = pc_q;
    // next PC: a redirect wins over a stall, otherwise step one word
    always_comb pc_next = branch_taken ? target : stall ? pc_q : pc_inc;
    // program counter
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pc_q <= RESET_PC;
        else          pc_q <= pc_next;
    // IF/ID register: kill on redirect/flush, freeze on stall, else capture
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n || branch_taken || flush) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall) begin
            instr_d    <= imem_rd;
            pc_d       <= pc_q;
            pc_plus4_d <= pc_inc;
            valid_d    <= 1'b1;
        end
`ifdef FETCH_ALIGN_CHECK_EN
    // sticky flag for any redirect whose low address bits are nonzero
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) misalign_err <= 1'b0;
        else if (branch_taken && |branch_target[1:0]) misalign_err <= 1'b1;
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^branch_target[1:0];
    assign misalign_err       = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a word-level fetch model
module tb_fetch_stage;
    logic        clk = 1'b0, reset_n = 1'b0, stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
    logic [21:0] branch_target = '0;
    logic [21:0] imem_addr, imem_rd, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, misalign_err;

    typedef struct { int pc; int instr; int pcd; int pc4; bit valid; bit err; } exp_t;
    exp_t q[$];
    int   m_pc, m_instr, m_pcd, m_pc4, tests, fails;
    bit   m_valid, m_err;

    localparam int SPACE = 1 << 22;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .stall(stall), .flush(flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // word k of memory holds 0x100 + k
    function automatic int mem(input int a);
        return 'h100 + a / 4;
    endfunction

    assign imem_rd = 22'(mem(int'(imem_addr)));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
    endtask

    // called at a negedge: drive inputs, predict the state after the next posedge
    task automatic step(input bit st, input bit fl, input bit br, input int tgt);
        exp_t e;
        stall = st; flush = fl; branch_taken = br; branch_target = 22'(tgt);
        if (br || fl) begin
            m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0;
        end else if (!st) begin
            m_instr = mem(m_pc); m_pcd = m_pc; m_pc4 = (m_pc + 4) % SPACE; m_valid = 1;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        if (br && tgt % 4 != 0) m_err = 1;
`endif
        if (br) m_pc = tgt - tgt % 4;
        else if (!st) m_pc = (m_pc + 4) % SPACE;
        e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc4 = m_pc4; e.valid = m_valid; e.err = m_err;
        q.push_back(e);
        @(negedge clk);
    endtask

    // monitor: compare every presented IF/ID state with the oldest prediction
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("imem_addr", 32'(imem_addr), e.pc);
            chk("instr_d", 32'(instr_d), e.instr);
            chk("pc_d", 32'(pc_d), e.pcd);
            chk("pc_plus4_d", 32'(pc_plus4_d), e.pc4);
            chk("valid_d", 32'(valid_d), 32'(e.valid));
            chk("misalign_err", 32'(misalign_err), 32'(e.err));
        end
    end

    task automatic chk_reset_state(input string n);
        chk({n, "_pc"}, 32'(imem_addr), 0);
        chk({n, "_instr"}, 32'(instr_d), 0);
        chk({n, "_pcd"}, 32'(pc_d), 0);
        chk({n, "_pc4"}, 32'(pc_plus4_d), 0);
        chk({n, "_valid"}, 32'(valid_d), 0);
        chk({n, "_err"}, 32'(misalign_err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clk);
        chk_reset_state("reset");
        reset_n = 1'b1;
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(1, 0, 1, 'h20);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 1, 'h3FFFFC);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 'h22);
        step(0, 0, 1, 'h40);
        step(0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            int tgt;
            tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SPACE - 1)) : int'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) tgt = 'h3FFFFC;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, tgt);
        end
        #2;
        stall = 1'b1; branch_taken = 1'b1; branch_target = 22'h000123;
        #1 reset_n = 1'b0;
        #1 chk_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 22-bit pipelined core. Holds the program counter and drives the word address to the combinational instruction memory. Captures the returned instruction, its PC and PC+4 into the IF/ID pipeline register for the decode stage. Supports hazard-unit stall, pipeline flush and branch redirect from execute.

## Interface
Parameters:
- ADDR_W, 22, PC / instruction-memory address width (byte address)
- INSTR_W, 22, instruction width
- RESET_PC, 0, PC value loaded at reset
- NOP_INSTR, 0, instruction placed in IF/ID when the slot is killed

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  byte address to instruction memory; always equals pc_q
- imem_rd  in  INSTR_W  instruction read combinationally from imem_addr
- stall  in  1  hold PC and IF/ID (hazard unit)
- flush  in  1  kill IF/ID contents
- branch_taken  in  1  redirect PC to branch_target (execute stage)
- branch_target  in  ADDR_W  redirect byte address
- instr_d  out  INSTR_W  IF/ID instruction
- pc_d  out  ADDR_W  PC of instr_d
- pc_plus4_d  out  ADDR_W  pc_d + 4
- valid_d  out  1  IF/ID slot holds a real instruction
- misalign_err  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- Clock and reset are fixed: one clock (clk); reset_n is asynchronous and active-low.
- PC register pc_q, next-PC priority:
  - reset_n=0: RESET_PC.
  - branch_taken: {branch_target[ADDR_W-1:2], 2'b00}. Overrides stall.
  - stall: hold.
  - else: pc_q + 4.
- pc_q[1:0] is always 00. Instruction memory indexes with a[21:2].
- PC+4 is computed modulo 2^ADDR_W: 22'h3FFFFC + 4 = 22'h000000, with no flag.
- IF/ID register priority:
  - reset_n=0: instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
  - branch_taken or flush: instr_d=NOP_INSTR, valid_d=0, pc_d/pc_plus4_d=0.
  - stall: hold all fields.
  - else: instr_d<=imem_rd, pc_d<=pc_q, pc_plus4_d<=pc_q+4, valid_d<=1.
- flush without branch_taken kills IF/ID only. The PC advances, or holds if stall=1.
- flush and stall together: IF/ID is killed and the PC is held.
- Downstream stages must gate all side effects on valid_d. NOP_INSTR is not required to be architecturally inert.

## Timing
- Fetch latency is 1 cycle: when pc_q=A at edge N, instr_d/pc_d=A are valid after edge N.
- Instruction memory is combinational, so imem_rd must settle within the same cycle as imem_addr.
- Branch penalty is 1 killed slot: at the edge where branch_taken=1, IF/ID is cleared and pc_q=target. The target instruction appears in IF/ID at the next edge.
- Reset assertion clears all registers immediately (asynchronous), including mid-stall or mid-branch.
- First edge after reset_n rises captures the instruction at RESET_PC.
- stall held for K cycles freezes pc_q, instr_d, pc_d and valid_d for K edges, with no instruction lost or duplicated.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - At any edge with branch_taken=1 and branch_target[1:0]≠00, misalign_err sets to 1.
  - misalign_err is sticky until reset.
  - The redirect still uses the target with bits [1:0] forced to 00.
- FETCH_ALIGN_CHECK_EN undefined:
  - No check logic; misalign_err is tied to 0.
  - branch_target[1:0] is ignored.

## Test plan
- Reset/sequential fetch:
  - Stimulus: memory model word k = 22'h000100+k; reset then release.
  - Response: imem_addr steps 0,4,8,C. After successive edges, instr_d = 100,101,102 and pc_d = 0,4,8, with valid_d=1 from the first edge.
- Stall:
  - Stimulus: stall=1 for 3 cycles while pc_q=8.
  - Response: pc_q stays 8 and instr_d=101/pc_d=4 is held. After release, instr_d=102 then 103, with no gap or duplicate.
- Branch:
  - Stimulus: branch_taken=1, target=22'h000020, while pc_q=C; stall=1 in the same cycle.
  - Response: next edge valid_d=0, instr_d=NOP_INSTR, pc_q=20. Following edge instr_d=108, pc_d=20.
- Flush only:
  - Stimulus: flush=1 one cycle at pc_q=4.
  - Response: valid_d=0 and pc_q=8. Next edge instr_d=102, valid_d=1.
- Wrap:
  - Stimulus: branch to 22'h3FFFFC.
  - Response: pc_plus4_d=0 after capture, and pc_q=0 the following cycle.
- Misalign/reset:
  - Stimulus: branch to 22'h000022 with FETCH_ALIGN_CHECK_EN defined.
  - Response: pc_q=20 and misalign_err=1, held through later branches. Asserting reset_n=0 mid-cycle clears it and sets pc_q=RESET_PC without waiting for a clock edge.
